// File: rtl/axis_framer_pkg.sv
// Shared types and defaults for the AXI4-Stream packet framer.
package axis_framer_pkg;

   localparam int LEN_W_DFLT = 16;
   localparam int CNT_W_DFLT = 32;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

   typedef logic [LEN_W_DFLT-1:0] len_t;
   typedef logic [CNT_W_DFLT-1:0] cnt_t;

   localparam cnt_t CONTINUOUS = '0;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer: registered in_ready, one-cycle latency, full throughput.
module axis_skid_buffer #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         empty
);

   logic [W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
   logic         out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
   logic         in_hs, out_hs;

   assign in_ready  = ~skid_valid_q;
   assign in_hs     = in_valid & in_ready;
   assign out_hs    = out_valid_q & out_ready;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign empty     = ~out_valid_q & ~skid_valid_q;

   always_comb begin
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      skid_data_d  = skid_data_q;
      skid_valid_d = skid_valid_q;
      if (out_hs || !out_valid_q) begin
         // Output register free: refill from skid first to keep order.
         if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = in_hs;
            if (in_hs) out_data_d = in_data;
         end
      end else if (in_hs) begin
         skid_data_d  = in_data;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         skid_data_q  <= skid_data_d;
         skid_valid_q <= skid_valid_d;
      end
   end

endmodule

// File: rtl/axis_packet_framer.sv
// Cuts a continuous AXI4-Stream into fixed-length packets with tlast, optional packet-count stop.
module axis_packet_framer
   import axis_framer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = LEN_W_DFLT,
   parameter int CNT_WIDTH  = CNT_W_DFLT
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cfg_enable,
   input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
   input  logic [CNT_WIDTH-1:0]  cfg_num_pkts,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  pkt_done,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  pkts_sent
);

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d, beat_cnt_q, beat_cnt_d;
   logic [CNT_WIDTH-1:0] num_q, num_d, in_pkts_q, in_pkts_d, pkts_sent_q, pkts_sent_d;
   logic                 accept_q, accept_d, pkt_done_q, pkt_done_d;
   logic                 skid_in_ready, buf_empty, in_hs, m_hs;
   logic                 last_beat, tag_last, final_pkt;
   logic [DATA_WIDTH:0]  skid_out;

   assign s_axis_tready = accept_q & skid_in_ready;
   assign in_hs         = s_axis_tvalid & s_axis_tready;
   assign m_hs          = m_axis_tvalid & m_axis_tready;
   assign last_beat     = (beat_cnt_q == len_q - LEN_WIDTH'(1));
   assign tag_last      = in_hs & last_beat;
   assign final_pkt     = tag_last && (num_q != CNT_WIDTH'(CONTINUOUS)) &&
                          (in_pkts_q + CNT_WIDTH'(1) == num_q);

   axis_skid_buffer #(.W(DATA_WIDTH + 1)) u_skid (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .in_data   ({last_beat, s_axis_tdata}),
      .in_valid  (in_hs),
      .in_ready  (skid_in_ready),
      .out_data  (skid_out),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready),
      .empty     (buf_empty)
   );

   assign m_axis_tlast = skid_out[DATA_WIDTH];
   assign m_axis_tdata = skid_out[DATA_WIDTH-1:0];
   assign pkt_done     = pkt_done_q;
   assign pkts_sent    = pkts_sent_q;
   assign busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      num_d       = num_q;
      beat_cnt_d  = beat_cnt_q;
      in_pkts_d   = in_pkts_q;
      accept_d    = accept_q;
      pkt_done_d  = m_hs & m_axis_tlast;
      pkts_sent_d = pkts_sent_q + CNT_WIDTH'(pkt_done_d);

      if (in_hs) begin
         beat_cnt_d = last_beat ? '0 : beat_cnt_q + LEN_WIDTH'(1);
         if (last_beat) in_pkts_d = in_pkts_q + CNT_WIDTH'(1);
      end

      case (state_q)
         ST_IDLE: begin
            accept_d = 1'b0;
            if (cfg_enable && cfg_pkt_len != '0) begin
               state_d     = ST_RUN;
               len_d       = cfg_pkt_len;
               num_d       = cfg_num_pkts;
               beat_cnt_d  = '0;
               in_pkts_d   = '0;
               pkts_sent_d = '0;
               accept_d    = 1'b1;
            end
         end
         ST_RUN: begin
            // accept_q low while in RUN means the packet quota was reached.
            if (final_pkt) begin
               accept_d = 1'b0;
            end else if (!accept_q) begin
               if (buf_empty) state_d = ST_DONE;
            end else if (!cfg_enable) begin
               if (beat_cnt_d == '0) begin
                  accept_d = 1'b0;
                  state_d  = (buf_empty && !in_hs) ? ST_IDLE : ST_DRAIN;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (accept_q) begin
               if (tag_last) accept_d = 1'b0;
            end else if (buf_empty) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            accept_d = 1'b0;
            if (!cfg_enable) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         num_q       <= '0;
         beat_cnt_q  <= '0;
         in_pkts_q   <= '0;
         pkts_sent_q <= '0;
         accept_q    <= 1'b0;
         pkt_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         num_q       <= num_d;
         beat_cnt_q  <= beat_cnt_d;
         in_pkts_q   <= in_pkts_d;
         pkts_sent_q <= pkts_sent_d;
         accept_q    <= accept_d;
         pkt_done_q  <= pkt_done_d;
      end
   end

endmodule

// File: tb/tb_axis_packet_framer.sv
// Randomized bench for axis_packet_framer against a beat-queue reference model.
module tb_axis_packet_framer;

   localparam int DW = 32;
   localparam int LW = 16;
   localparam int CW = 32;

   logic          ACLK = 1'b0;
   logic          ARESETN = 1'b0;
   logic          cfg_enable = 1'b0;
   logic [LW-1:0] cfg_pkt_len = '0;
   logic [CW-1:0] cfg_num_pkts = '0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic          pkt_done;
   logic          busy;
   logic [CW-1:0] pkts_sent;

   axis_packet_framer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable),
      .cfg_pkt_len(cfg_pkt_len), .cfg_num_pkts(cfg_num_pkts),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .pkt_done(pkt_done), .busy(busy), .pkts_sent(pkts_sent)
   );

   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // Reference model: the k-th accepted beat since start closes a packet when k % len == 0.
   int            cur_len = 0, cur_num = 0;
   int            acc_cnt = 0, out_pkts = 0, pd_cnt = 0, rdy_seen = 0;
   logic [DW:0]   exp_q[$];
   logic [DW:0]   mon_e;
   logic [DW:0]   stall_val = '0;
   logic          s_hs_seen = 1'b0, pd_pend = 1'b0, stall_prev = 1'b0;

   int            next_data = 1, sent = 0, src_limit = 0;
   bit            src_on = 1'b0, src_rand = 1'b0, snk_rand = 1'b0;

   task automatic model_clear();
      exp_q.delete();
      acc_cnt = 0; out_pkts = 0; pd_cnt = 0; rdy_seen = 0;
   endtask

   always @(negedge ACLK) begin
      chk("pkt_done", 64'(pkt_done), 64'(pd_pend));
      if (stall_prev)
         chk("stable", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 64'({1'b1, stall_val}));
      if (!ARESETN) begin
         exp_q.delete();
         acc_cnt = 0; out_pkts = 0; pd_cnt = 0; rdy_seen = 0;
         s_hs_seen = 1'b0; pd_pend = 1'b0; stall_prev = 1'b0;
      end else begin
         if (s_axis_tvalid && s_axis_tready) begin
            acc_cnt++;
            if (cur_num != 0) chk("overrun", 64'(acc_cnt > cur_len * cur_num), 64'd0);
            exp_q.push_back({(cur_len != 0) && (acc_cnt % cur_len == 0), s_axis_tdata});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) chk("spurious", 64'(exp_q.size()), 64'd1);
            else begin
               mon_e = exp_q.pop_front();
               chk("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'(mon_e));
               if (m_axis_tlast) out_pkts++;
            end
         end
         if (s_axis_tready) rdy_seen++;
         if (pkt_done) pd_cnt++;
         s_hs_seen  = s_axis_tvalid & s_axis_tready;
         pd_pend    = m_axis_tvalid & m_axis_tready & m_axis_tlast;
         stall_prev = m_axis_tvalid & ~m_axis_tready;
         stall_val  = {m_axis_tlast, m_axis_tdata};
      end
   end

   task automatic step();
      logic hs;
      @(posedge ACLK);
      #1;
      hs = s_hs_seen;
      s_hs_seen = 1'b0;
      if (hs) begin next_data++; sent++; end
      if (!s_axis_tvalid || hs)
         s_axis_tvalid = src_on && (sent < src_limit) && (!src_rand || $urandom_range(0, 1) == 1);
      s_axis_tdata  = DW'(next_data);
      m_axis_tready = !snk_rand || ($urandom_range(0, 1) == 1);
   endtask

   task automatic wait_quiet(input string tag);
      int n = 0;
      while ((busy || m_axis_tvalid || exp_q.size() != 0) && n < 2000) begin step(); n++; end
      chk(tag, 64'(n < 2000), 64'd1);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((sent < src_limit || m_axis_tvalid || exp_q.size() != 0) && n < 2000) begin step(); n++; end
      chk(tag, 64'(n < 2000), 64'd1);
   endtask

   task automatic start(input int len, input int num, input bit sr, input bit kr);
      model_clear();
      cur_len = len; cur_num = num;
      cfg_pkt_len = LW'(len); cfg_num_pkts = CW'(num);
      src_rand = sr; snk_rand = kr; src_on = 1'b1;
      cfg_enable = 1'b1;
      step();
   endtask

   initial begin
      int n, len, num;
      repeat (3) step();
      chk("rst_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_tlast",  64'(m_axis_tlast), 64'd0);
      chk("rst_done",   64'(pkt_done), 64'd0);
      chk("rst_busy",   64'(busy), 64'd0);
      chk("rst_sent",   64'(pkts_sent), 64'd0);
      ARESETN = 1'b1;
      step();

      // len=4, num=3, always ready
      next_data = 1; src_limit = 1000;
      start(4, 3, 1'b0, 1'b0);
      wait_quiet("t1_timeout");
      repeat (5) step();
      chk("t1_acc",   64'(acc_cnt), 64'd12);
      chk("t1_pkts",  64'(out_pkts), 64'd3);
      chk("t1_pd",    64'(pd_cnt), 64'd3);
      chk("t1_sent",  64'(pkts_sent), 64'd3);
      chk("t1_busy",  64'(busy), 64'd0);
      chk("t1_rdy",   64'(s_axis_tready), 64'd0);
      cfg_enable = 1'b0;
      repeat (2) step();

      // len=1, continuous, 10 beats; pkts_sent cleared on start
      src_limit = sent + 10;
      start(1, 0, 1'b0, 1'b0);
      chk("t2_clear", 64'(pkts_sent), 64'd0);
      n = 0;
      while (sent < src_limit && n < 500) begin chk("t2_busy", 64'(busy), 64'd1); step(); n++; end
      wait_drain("t2_timeout");
      chk("t2_busy_end", 64'(busy), 64'd1);
      chk("t2_sent", 64'(pkts_sent), 64'd10);
      chk("t2_pkts", 64'(out_pkts), 64'd10);
      cfg_enable = 1'b0;
      repeat (2) step();
      chk("t2_idle", 64'(busy), 64'd0);

      // len=5, drop enable after beat 2: packet completes, no truncation
      src_limit = sent + 1000;
      start(5, 0, 1'b0, 1'b0);
      n = 0;
      while (acc_cnt < 2 && n < 100) begin step(); n++; end
      cfg_enable = 1'b0;
      wait_quiet("t3_timeout");
      repeat (3) step();
      chk("t3_acc",  64'(acc_cnt), 64'd5);
      chk("t3_sent", 64'(pkts_sent), 64'd1);
      chk("t3_busy", 64'(busy), 64'd0);
      chk("t3_rdy",  64'(s_axis_tready), 64'd0);

      // len=4, num=2, random source and sink
      start(4, 2, 1'b1, 1'b1);
      wait_quiet("t4_timeout");
      chk("t4_acc",  64'(acc_cnt), 64'd8);
      chk("t4_sent", 64'(pkts_sent), 64'd2);
      chk("t4_pd",   64'(pd_cnt), 64'd2);
      cfg_enable = 1'b0;
      repeat (2) step();

      // random configurations
      for (int it = 0; it < 6; it++) begin
         len = int'($urandom_range(1, 6));
         num = int'($urandom_range(1, 4));
         start(len, num, 1'b1, 1'b1);
         wait_quiet("rnd_timeout");
         chk("rnd_acc",  64'(acc_cnt), 64'(len * num));
         chk("rnd_sent", 64'(pkts_sent), 64'(num));
         cfg_enable = 1'b0;
         repeat (2) step();
      end

      // zero length never starts
      start(0, 0, 1'b0, 1'b0);
      repeat (20) step();
      chk("t5_rdy",  64'(rdy_seen), 64'd0);
      chk("t5_acc",  64'(acc_cnt), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_out",  64'(m_axis_tvalid), 64'd0);

      // reset during beat 3 of a len=8 packet, then a fresh packet
      start(8, 0, 1'b0, 1'b0);
      n = 0;
      while (acc_cnt < 3 && n < 100) begin step(); n++; end
      ARESETN = 1'b0;
      step();
      chk("t6_rdy",   64'(s_axis_tready), 64'd0);
      chk("t6_vld",   64'(m_axis_tvalid), 64'd0);
      chk("t6_last",  64'(m_axis_tlast), 64'd0);
      chk("t6_done",  64'(pkt_done), 64'd0);
      chk("t6_busy",  64'(busy), 64'd0);
      chk("t6_sent",  64'(pkts_sent), 64'd0);
      src_limit = sent + 8;
      ARESETN = 1'b1;
      step();
      chk("t6_restart", 64'(busy), 64'd1);
      chk("t6_clear",   64'(pkts_sent), 64'd0);
      wait_drain("t6_timeout");
      chk("t6_acc",   64'(acc_cnt), 64'd8);
      chk("t6_fresh", 64'(pkts_sent), 64'd1);
      chk("t6_pkts",  64'(out_pkts), 64'd1);
      cfg_enable = 1'b0;
      repeat (3) step();
      chk("t6_idle", 64'(busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
